// File: rtl/sh1_pkg.sv
// sh1_pkg: shared constants and types for the SH-1 register file slice.
//   XLEN   - default register width
//   NREGS  - default register count (power of two)
//   NRD    - default number of read ports
//   AW     - register address width
//   reg_addr_t - register index type
//   R0_IDX - index of R0 (implicit operand of several SH-1 instructions)
package sh1_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t R0_IDX = '0;
endpackage

// File: rtl/sh1_scoreboard.sv
// sh1_scoreboard: per-register load scoreboard for the SH-1 register file.
// Tracks one pending load per register, accepts reserve requests through a
// valid/ready handshake, clears entries on load return or pipeline flush, and
// raises a sticky hazard error.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   i_wa_en, i_wa_addr     ALU write port (checked for WAW against pending loads)
//   i_wb_en, i_wb_addr     load return write port (clears busy)
//   i_ld_valid, i_ld_addr  reserve request
//   i_flush                clear all busy bits, block reserves
//   o_ld_ready             reserve can be accepted this cycle
//   o_busy_vec             current busy bits
//   o_err                  sticky hazard error
module sh1_scoreboard #(
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wa_en,
  input  logic [AW-1:0]    i_wa_addr,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic             i_ld_valid,
  input  logic [AW-1:0]    i_ld_addr,
  input  logic             i_flush,
  output logic             o_ld_ready,
  output logic [NREGS-1:0] o_busy_vec,
  output logic             o_err
);
  import sh1_pkg::*;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             r_flush_d;
  logic             r_err;
  logic             w_accept;
  logic             w_err_set;

  // A register whose load returns this cycle can be reserved again at once.
  assign o_ld_ready = ~i_flush &
                      (~r_busy[i_ld_addr] | (i_wb_en & (i_wb_addr == i_ld_addr)));
  assign w_accept   = i_ld_valid & o_ld_ready;

  // Reserve is applied after the return clear so a same-register
  // return + re-reserve leaves the entry busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (i_wb_en)  w_busy_nxt[i_wb_addr] = 1'b0;
      if (w_accept) w_busy_nxt[i_ld_addr] = 1'b1;
    end
  end

  // A return right after a flush belongs to a load the flush discarded,
  // so it is not treated as spurious.
  assign w_err_set = (i_wa_en & r_busy[i_wa_addr]) |
                     (i_wb_en & ~r_busy[i_wb_addr] & ~r_flush_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_flush_d <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_flush_d <= i_flush;
      r_err     <= r_err | w_err_set;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_err      = r_err;
endmodule

// File: rtl/sh1_regfile_sb.sv
// sh1_regfile_sb: SH-1 general-purpose register file with load scoreboard.
// NRD combinational read ports, two write ports (A: ALU, B: load return, A
// wins on collision), optional same-cycle write bypass, and a busy-bit
// scoreboard so decode can stall on pending loads.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_rd_addr  [NRD*AW]        read addresses, port i at [i*AW +: AW]
//   o_rd_data  [NRD*XLEN]      read data, port i at [i*XLEN +: XLEN]
//   o_rd_busy  [NRD]           addressed register has a pending load
//   i_wa_en/i_wa_addr/i_wa_data  write port A (ALU)
//   i_wb_en/i_wb_addr/i_wb_data  write port B (load return, clears busy)
//   i_ld_valid, i_ld_addr      load reserve request
//   o_ld_ready                 reserve accepted when valid & ready
//   i_flush                    clear all busy bits
//   o_busy_vec [NREGS]         scoreboard state
//   o_err                      sticky hazard error
module sh1_regfile_sb #(
  parameter int XLEN   = sh1_pkg::XLEN,
  parameter int NREGS  = sh1_pkg::NREGS,
  parameter int NRD    = sh1_pkg::NRD,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic                i_wa_en,
  input  logic [AW-1:0]       i_wa_addr,
  input  logic [XLEN-1:0]     i_wa_data,
  input  logic                i_wb_en,
  input  logic [AW-1:0]       i_wb_addr,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_ld_valid,
  input  logic [AW-1:0]       i_ld_addr,
  output logic                o_ld_ready,
  input  logic                i_flush,
  output logic [NREGS-1:0]    o_busy_vec,
  output logic                o_err
);
  import sh1_pkg::*;

  localparam logic P_BYP = (BYPASS != 0);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy_vec;

  // Port B is written first so port A overrides it on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NREGS; j++) r_regs[j] <= '0;
    end else begin
      if (i_wb_en) r_regs[i_wb_addr] <= i_wb_data;
      if (i_wa_en) r_regs[i_wa_addr] <= i_wa_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_wa_hit;
    logic          w_wb_hit;

    assign w_addr   = i_rd_addr[g*AW +: AW];
    assign w_wa_hit = P_BYP & i_wa_en & (i_wa_addr == w_addr);
    assign w_wb_hit = P_BYP & i_wb_en & (i_wb_addr == w_addr);

    assign o_rd_data[g*XLEN +: XLEN] = w_wa_hit ? i_wa_data :
                                       w_wb_hit ? i_wb_data : r_regs[w_addr];
    // A returning load is forwarded, so the reader need not stall on it.
    assign o_rd_busy[g] = w_busy_vec[w_addr] & ~w_wb_hit;
  end

  sh1_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wa_en    (i_wa_en),
    .i_wa_addr  (i_wa_addr),
    .i_wb_en    (i_wb_en),
    .i_wb_addr  (i_wb_addr),
    .i_ld_valid (i_ld_valid),
    .i_ld_addr  (i_ld_addr),
    .i_flush    (i_flush),
    .o_ld_ready (o_ld_ready),
    .o_busy_vec (w_busy_vec),
    .o_err      (o_err)
  );

  assign o_busy_vec = w_busy_vec;
endmodule

// File: tb/tb_sh1_regfile_sb.sv
module tb_sh1_regfile_sb;
  import sh1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rd_addr;
  logic [95:0] rd_data, rd_data_nb;
  logic [2:0]  rd_busy, rd_busy_nb;
  logic        wa_en, wb_en, ld_valid, flush;
  logic [3:0]  wa_addr, wb_addr, ld_addr;
  logic [31:0] wa_data, wb_data;
  logic        ld_ready, ld_ready_nb, err, err_nb;
  logic [15:0] busy_vec, busy_vec_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sh1_regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_busy(rd_busy), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .o_ld_ready(ld_ready),
    .i_flush(flush), .o_busy_vec(busy_vec), .o_err(err));

  sh1_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_nb),
    .o_rd_busy(rd_busy_nb), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .o_ld_ready(ld_ready_nb),
    .i_flush(flush), .o_busy_vec(busy_vec_nb), .o_err(err_nb));

  // Reference model: architectural state only.
  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_err;
  logic        m_flush_prev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0;
    m_err = 1'b0;
    m_flush_prev = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a, input bit byp);
    if (byp && wa_en && wa_addr == a) return wa_data;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_ready();
    return !flush && (!m_busy[ld_addr] || (wb_en && wb_addr == ld_addr));
  endfunction

  task automatic model_check();
    logic [3:0] a;
    for (int i = 0; i < 3; i++) begin
      a = rd_addr[i*4 +: 4];
      check($sformatf("rd_data%0d", i), rd_data[i*32 +: 32], m_read(a, 1'b1));
      check($sformatf("rd_data_nb%0d", i), rd_data_nb[i*32 +: 32], m_read(a, 1'b0));
      check($sformatf("rd_busy%0d", i), {31'b0, rd_busy[i]},
            {31'b0, m_busy[a] && !(wb_en && wb_addr == a)});
      check($sformatf("rd_busy_nb%0d", i), {31'b0, rd_busy_nb[i]}, {31'b0, m_busy[a]});
    end
    check("ld_ready", {31'b0, ld_ready}, {31'b0, m_ready()});
    check("ld_ready_nb", {31'b0, ld_ready_nb}, {31'b0, m_ready()});
    check("busy_vec", {16'b0, busy_vec}, {16'b0, m_busy});
    check("busy_vec_nb", {16'b0, busy_vec_nb}, {16'b0, m_busy});
    check("err", {31'b0, err}, {31'b0, m_err});
    check("err_nb", {31'b0, err_nb}, {31'b0, m_err});
  endtask

  task automatic model_step();
    logic acc;
    acc = ld_valid && m_ready();
    if ((wa_en && m_busy[wa_addr]) || (wb_en && !m_busy[wb_addr] && !m_flush_prev))
      m_err = 1'b1;
    if (wb_en) m_regs[wb_addr] = wb_data;
    if (wa_en) m_regs[wa_addr] = wa_data;
    if (flush) m_busy = '0;
    else begin
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (acc)   m_busy[ld_addr] = 1'b1;
    end
    m_flush_prev = flush;
  endtask

  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    ld_valid = 0; ld_addr = 0; flush = 0;
    rd_addr = {R0_IDX, R0_IDX, R0_IDX};
  endtask

  // Inputs are set just after a rising edge; check at falling edge, then commit.
  task automatic cycle();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wa_en;  logic [3:0] wa_addr; logic [31:0] wa_data;
    logic        wb_en;  logic [3:0] wb_addr; logic [31:0] wb_data;
    logic        ld_valid; logic [3:0] ld_addr; logic flush; logic [3:0] ra;
    logic [31:0] e_rd;   logic [31:0] e_rd_nb;
    logic        e_rb;   logic e_rb_nb; logic e_rdy; logic [15:0] e_busy; logic e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic wae, input logic [3:0] waa, input logic [31:0] wad,
    input logic wbe, input logic [3:0] wba, input logic [31:0] wbd,
    input logic lv, input logic [3:0] la, input logic fl, input logic [3:0] ra,
    input logic [31:0] erd, input logic [31:0] erdnb,
    input logic erb, input logic erbnb, input logic erdy, input logic [15:0] ebusy,
    input logic eerr);
    vec_t v;
    v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
    v.ld_valid = lv; v.ld_addr = la; v.flush = fl; v.ra = ra;
    v.e_rd = erd; v.e_rd_nb = erdnb; v.e_rb = erb; v.e_rb_nb = erbnb;
    v.e_rdy = erdy; v.e_busy = ebusy; v.e_err = eerr;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    //             wa            wb            ld     fl ra  rd        rd_nb     rb rbn rdy busy     err
    tbl[0]  = mk(1, 5, 32'h1234, 0, 0, 0,      0, 0, 0, 5, 32'h1234, 32'h0,    0, 0, 1, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 0,        0, 0, 0,      0, 0, 0, 5, 32'h1234, 32'h1234, 0, 0, 1, 16'h0000, 0);
    tbl[2]  = mk(0, 0, 0,        0, 0, 0,      1, 7, 0, 7, 32'h0,    32'h0,    0, 0, 1, 16'h0000, 0);
    tbl[3]  = mk(0, 0, 0,        0, 0, 0,      1, 7, 0, 7, 32'h0,    32'h0,    1, 1, 0, 16'h0080, 0);
    tbl[4]  = mk(0, 0, 0,        1, 7, 32'h55, 0, 7, 0, 7, 32'h55,   32'h0,    0, 1, 1, 16'h0080, 0);
    tbl[5]  = mk(0, 0, 0,        0, 0, 0,      1, 7, 0, 7, 32'h55,   32'h55,   0, 0, 1, 16'h0000, 0);
    tbl[6]  = mk(0, 0, 0,        1, 7, 32'h66, 1, 7, 0, 7, 32'h66,   32'h55,   0, 1, 1, 16'h0080, 0);
    tbl[7]  = mk(0, 0, 0,        0, 0, 0,      0, 7, 0, 7, 32'h66,   32'h66,   1, 1, 0, 16'h0080, 0);
    tbl[8]  = mk(0, 0, 0,        1, 7, 32'h77, 0, 7, 0, 7, 32'h77,   32'h66,   0, 1, 1, 16'h0080, 0);
    tbl[9]  = mk(0, 0, 0,        0, 0, 0,      1, 1, 0, 1, 32'h0,    32'h0,    0, 0, 1, 16'h0000, 0);
    tbl[10] = mk(0, 0, 0,        0, 0, 0,      1, 4, 0, 1, 32'h0,    32'h0,    1, 1, 1, 16'h0002, 0);
    tbl[11] = mk(0, 0, 0,        0, 0, 0,      1, 9, 1, 4, 32'h0,    32'h0,    1, 1, 0, 16'h0012, 0);
    tbl[12] = mk(0, 0, 0,        1, 1, 32'h11, 0, 9, 0, 1, 32'h11,   32'h0,    0, 0, 1, 16'h0000, 0);
    tbl[13] = mk(0, 0, 0,        0, 0, 0,      0, 9, 0, 1, 32'h11,   32'h11,   0, 0, 1, 16'h0000, 0);
    tbl[14] = mk(1, 2, 32'hA,    1, 2, 32'hB,  0, 9, 0, 2, 32'hA,    32'h0,    0, 0, 1, 16'h0000, 0);
    tbl[15] = mk(0, 0, 0,        0, 0, 0,      0, 9, 0, 2, 32'hA,    32'hA,    0, 0, 1, 16'h0000, 1);

    idle();
    do_reset();

    // Directed table: bypass, A-over-B priority, reserve handshake, flush.
    for (int i = 0; i < 16; i++) begin
      wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_addr; wa_data = tbl[i].wa_data;
      wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      ld_valid = tbl[i].ld_valid; ld_addr = tbl[i].ld_addr; flush = tbl[i].flush;
      rd_addr = {R0_IDX, R0_IDX, tbl[i].ra};
      @(negedge clk);
      check($sformatf("tbl%0d rd0", i), rd_data[31:0], tbl[i].e_rd);
      check($sformatf("tbl%0d rd0_nb", i), rd_data_nb[31:0], tbl[i].e_rd_nb);
      check($sformatf("tbl%0d rbusy0", i), {31'b0, rd_busy[0]}, {31'b0, tbl[i].e_rb});
      check($sformatf("tbl%0d rbusy0_nb", i), {31'b0, rd_busy_nb[0]}, {31'b0, tbl[i].e_rb_nb});
      check($sformatf("tbl%0d ld_ready", i), {31'b0, ld_ready}, {31'b0, tbl[i].e_rdy});
      check($sformatf("tbl%0d busy_vec", i), {16'b0, busy_vec}, {16'b0, tbl[i].e_busy});
      check($sformatf("tbl%0d err", i), {31'b0, err}, {31'b0, tbl[i].e_err});
      model_check();
      model_step();
      @(posedge clk);
      #1;
    end

    // Reset asserted asynchronously in the middle of a write to R3.
    idle();
    wa_en = 1; wa_addr = 3; wa_data = 32'hDEAD_BEEF;
    #3 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    wa_en = 0;
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(a), 4'(a), 4'(a)};
      #1;
      check($sformatf("rst rd R%0d", a), rd_data[31:0], 32'h0);
      check($sformatf("rst rd_nb R%0d", a), rd_data_nb[31:0], 32'h0);
    end
    check("rst busy_vec", {16'b0, busy_vec}, 32'h0);
    check("rst err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // WAW against a pending load sets a sticky error.
    ld_valid = 1; ld_addr = 4;
    cycle();
    idle(); wa_en = 1; wa_addr = 4; wa_data = 32'h1;
    cycle();
    idle();
    check("waw err set", {31'b0, err}, 32'h1);
    wb_en = 1; wb_addr = 4; wb_data = 32'h2;
    cycle();
    idle();
    repeat (3) cycle();
    check("waw err sticky", {31'b0, err}, 32'h1);

    // Spurious load return.
    do_reset();
    check("err after reset", {31'b0, err}, 32'h0);
    wb_en = 1; wb_addr = 9; wb_data = 32'h9;
    cycle();
    idle();
    check("spurious wb err", {31'b0, err}, 32'h1);

    // Randomised traffic against the model, with periodic resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int s;
      if (n % 150 == 149) do_reset();
      wa_en = ($urandom_range(0, 3) == 0);
      wa_addr = 4'($urandom_range(0, 15));
      wa_data = $urandom;
      wb_en = ($urandom_range(0, 2) == 0);
      wb_addr = 4'($urandom_range(0, 15));
      if (m_busy != 0 && $urandom_range(0, 3) != 0) begin
        s = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          if (m_busy[(s + k) % 16]) begin
            wb_addr = 4'((s + k) % 16);
            break;
          end
        end
      end
      wb_data = $urandom;
      ld_valid = ($urandom_range(0, 1) == 0);
      ld_addr = ($urandom_range(0, 2) == 0) ? wb_addr : 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 3))
          0: rd_addr[i*4 +: 4] = wa_addr;
          1: rd_addr[i*4 +: 4] = wb_addr;
          default: rd_addr[i*4 +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
